// File: rtl/q_learning_accel_param.sv
// q_learning_accel_param
// Handshaked Q-learning update engine with an internal flop-array Q-table.
// Each accepted request runs one Bellman update through READ -> MAX -> CALC
// -> WRITE, then reports the pre-update next-state row, its greedy action
// and the committed value. A clear command zeroes one state row per cycle.
module q_learning_accel_param #(
    parameter  int DATA_W = 32,
    parameter  int N_ST   = 256,
    parameter  int N_ACT  = 4,
    parameter  int COEF_W = 8,
    localparam int ST_W   = $clog2(N_ST),
    localparam int ACT_W  = $clog2(N_ACT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ST_W-1:0]         st,
    input  logic [ST_W-1:0]         nxtst,
    input  logic [ACT_W-1:0]        act,
    input  logic [DATA_W-1:0]       rt,
    input  logic [COEF_W-1:0]       alpha,
    input  logic [COEF_W-1:0]       gamma,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    done,
    output logic                    err,
    output logic [N_ACT*DATA_W-1:0] q_row,
    output logic [ACT_W-1:0]        best_act,
    output logic [DATA_W-1:0]       q_new
);

    // Internal arithmetic width: wide enough that neither product nor the
    // temporal difference can overflow before the final saturation.
    localparam int IW = DATA_W + COEF_W + 2;

    localparam logic signed [IW-1:0] Q_MAX = {{(IW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [IW-1:0] Q_MIN = {{(IW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MAX,
        S_CALC,
        S_WRITE,
        S_CLEAR
    } state_e;

    state_e                     state_q, state_d;

    // Request fields captured at acceptance.
    logic [ST_W-1:0]            st_q, st_d;
    logic [ST_W-1:0]            nxtst_q, nxtst_d;
    logic [ACT_W-1:0]           act_q, act_d;
    logic signed [DATA_W-1:0]   rt_q, rt_d;
    logic [COEF_W-1:0]          alpha_q, alpha_d;
    logic [COEF_W-1:0]          gamma_q, gamma_d;

    // Pipeline working registers.
    logic signed [DATA_W-1:0]   row_q [N_ACT];
    logic signed [DATA_W-1:0]   row_d [N_ACT];
    logic signed [DATA_W-1:0]   qsa_q, qsa_d;
    logic signed [DATA_W-1:0]   qmax_q, qmax_d;
    logic [ACT_W-1:0]           best_q, best_d;
    logic signed [DATA_W-1:0]   qn_q, qn_d;
    logic [ST_W-1:0]            clr_idx_q, clr_idx_d;

    // Registered outputs.
    logic [N_ACT*DATA_W-1:0]    q_row_q, q_row_d;
    logic [ACT_W-1:0]           best_act_q, best_act_d;
    logic [DATA_W-1:0]          q_new_q, q_new_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    // Q-table and its write controls.
    logic signed [DATA_W-1:0]   tbl_q [N_ST][N_ACT];
    logic                       tbl_wr;
    logic                       tbl_clr;

    logic                       req_in_range;
    logic signed [DATA_W-1:0]   scan_max;
    logic [ACT_W-1:0]           scan_idx;
    logic signed [IW-1:0]       rt_x, qsa_x, qmax_x, alpha_x, gamma_x;
    logic signed [IW-1:0]       gq_prod, td, at_prod, qn_wide;
    logic signed [DATA_W-1:0]   qn_sat;

    assign req_in_range = (int'(st) < N_ST) && (int'(nxtst) < N_ST) && (int'(act) < N_ACT);

    // Signed maximum of the registered row; strict compare keeps the lowest index on ties.
    always_comb begin
        scan_max = row_q[0];
        scan_idx = '0;
        for (int a = 1; a < N_ACT; a++) begin
            if (row_q[a] > scan_max) begin
                scan_max = row_q[a];
                scan_idx = ACT_W'(a);
            end
        end
    end

    // Bellman update in the wide domain, then clamp back to DATA_W.
    always_comb begin
        rt_x    = $signed({{(IW-DATA_W){rt_q[DATA_W-1]}}, rt_q});
        qsa_x   = $signed({{(IW-DATA_W){qsa_q[DATA_W-1]}}, qsa_q});
        qmax_x  = $signed({{(IW-DATA_W){qmax_q[DATA_W-1]}}, qmax_q});
        alpha_x = $signed({{(IW-COEF_W){1'b0}}, alpha_q});
        gamma_x = $signed({{(IW-COEF_W){1'b0}}, gamma_q});
        gq_prod = gamma_x * qmax_x;
        td      = rt_x + (gq_prod >>> COEF_W) - qsa_x;
        at_prod = alpha_x * td;
        qn_wide = qsa_x + (at_prod >>> COEF_W);
        if (qn_wide > Q_MAX) begin
            qn_sat = Q_MAX[DATA_W-1:0];
        end else if (qn_wide < Q_MIN) begin
            qn_sat = Q_MIN[DATA_W-1:0];
        end else begin
            qn_sat = qn_wide[DATA_W-1:0];
        end
    end

    // FSM next-state and datapath next-values.
    // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        st_d       = st_q;
        nxtst_d    = nxtst_q;
        act_d      = act_q;
        rt_d       = rt_q;
        alpha_d    = alpha_q;
        gamma_d    = gamma_q;
        row_d      = row_q;
        qsa_d      = qsa_q;
        qmax_d     = qmax_q;
        best_d     = best_q;
        qn_d       = qn_q;
        clr_idx_d  = clr_idx_q;
        q_row_d    = q_row_q;
        best_act_d = best_act_q;
        q_new_d    = q_new_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tbl_wr     = 1'b0;
        tbl_clr    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d   = S_CLEAR;
                    clr_idx_d = '0;
                end else if (in_valid) begin
                    if (req_in_range) begin
                        st_d    = st;
                        nxtst_d = nxtst;
                        act_d   = act;
                        rt_d    = $signed(rt);
                        alpha_d = alpha;
                        gamma_d = gamma;
                        state_d = S_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                for (int a = 0; a < N_ACT; a++) begin
                    row_d[a] = tbl_q[nxtst_q][a];
                end
                qsa_d   = tbl_q[st_q][act_q];
                state_d = S_MAX;
            end
            S_MAX: begin
                qmax_d  = scan_max;
                best_d  = scan_idx;
                state_d = S_CALC;
            end
            S_CALC: begin
                qn_d    = qn_sat;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                tbl_wr     = 1'b1;
                q_new_d    = qn_q;
                best_act_d = best_q;
                for (int a = 0; a < N_ACT; a++) begin
                    q_row_d[a*DATA_W +: DATA_W] = row_q[a];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_CLEAR: begin
                tbl_clr = 1'b1;
                if (clr_idx_q == ST_W'(N_ST - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control, pipeline and output registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            st_q       <= '0;
            nxtst_q    <= '0;
            act_q      <= '0;
            rt_q       <= '0;
            alpha_q    <= '0;
            gamma_q    <= '0;
            for (int a = 0; a < N_ACT; a++) begin
                row_q[a] <= '0;
            end
            qsa_q      <= '0;
            qmax_q     <= '0;
            best_q     <= '0;
            qn_q       <= '0;
            clr_idx_q  <= '0;
            q_row_q    <= '0;
            best_act_q <= '0;
            q_new_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            st_q       <= st_d;
            nxtst_q    <= nxtst_d;
            act_q      <= act_d;
            rt_q       <= rt_d;
            alpha_q    <= alpha_d;
            gamma_q    <= gamma_d;
            row_q      <= row_d;
            qsa_q      <= qsa_d;
            qmax_q     <= qmax_d;
            best_q     <= best_d;
            qn_q       <= qn_d;
            clr_idx_q  <= clr_idx_d;
            q_row_q    <= q_row_d;
            best_act_q <= best_act_d;
            q_new_q    <= q_new_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Q-table storage: row clear during CLEAR, single-entry commit in WRITE.
    // NOTE: the table is built from flops, so reset zeroes it outright; an abandoned update never reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < N_ST; s++) begin
                for (int a = 0; a < N_ACT; a++) begin
                    tbl_q[s][a] <= '0;
                end
            end
        end else if (tbl_clr) begin
            for (int a = 0; a < N_ACT; a++) begin
                tbl_q[clr_idx_q][a] <= '0;
            end
        end else if (tbl_wr) begin
            tbl_q[st_q][act_q] <= qn_q;
        end
    end

    assign in_ready = (state_q == S_IDLE) && !clr_req;
    assign clr_busy = (state_q == S_CLEAR);
    assign done     = done_q;
    assign err      = err_q;
    assign q_row    = q_row_q;
    assign best_act = best_act_q;
    assign q_new    = q_new_q;

endmodule

// File: tb/tb_q_learning_accel_param.sv
// tb_q_learning_accel_param
// Scoreboard bench: the driver computes each expected response from a
// behavioural Q-table model and queues it; a monitor pops and compares on
// every done pulse. A second instance with N_ST=12 covers index range errors.
module tb_q_learning_accel_param;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int NS = 16;
    localparam int NA = 4;

    typedef struct packed {
        logic [DW-1:0]    q_new;
        logic [NA*DW-1:0] row;
        logic [1:0]       best;
        logic [31:0]      cyc;
    } sb_item_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_ready;
    logic [3:0]     st, nxtst;
    logic [1:0]     act;
    logic [DW-1:0]  rt;
    logic [CW-1:0]  alpha, gamma;
    logic           clr_req, clr_busy, done, err;
    logic [NA*DW-1:0] q_row;
    logic [1:0]     best_act;
    logic [DW-1:0]  q_new;

    logic           in_valid12, in_ready12;
    logic [3:0]     st12, nxtst12;
    logic [1:0]     act12;
    logic [DW-1:0]  rt12;
    logic [CW-1:0]  alpha12, gamma12;
    logic           clr_req12, clr_busy12, done12, err12;
    logic [NA*DW-1:0] q_row12;
    logic [1:0]     best12;
    logic [DW-1:0]  q_new12;

    int       n_checks = 0;
    int       n_errors = 0;
    int       cyc = 0;
    int       accept_cyc = 0;
    int       last_accept = 0;
    longint   tbl_m [NS][NA];
    sb_item_t sb [$];

    q_learning_accel_param #(.DATA_W(DW), .N_ST(NS), .N_ACT(NA), .COEF_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .st(st), .nxtst(nxtst), .act(act), .rt(rt), .alpha(alpha), .gamma(gamma),
        .clr_req(clr_req), .clr_busy(clr_busy), .done(done), .err(err),
        .q_row(q_row), .best_act(best_act), .q_new(q_new)
    );

    q_learning_accel_param #(.DATA_W(DW), .N_ST(12), .N_ACT(NA), .COEF_W(CW)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid12), .in_ready(in_ready12),
        .st(st12), .nxtst(nxtst12), .act(act12), .rt(rt12), .alpha(alpha12), .gamma(gamma12),
        .clr_req(clr_req12), .clr_busy(clr_busy12), .done(done12), .err(err12),
        .q_row(q_row12), .best_act(best12), .q_new(q_new12)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check(input string name, input logic signed [63:0] actual,
                         input logic signed [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Floor division by 2^CW, rounding toward minus infinity.
    function automatic longint floor_div(input longint x);
        longint d;
        longint q;
        d = longint'(1) << CW;
        q = x / d;
        if ((x % d) != 0 && x < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint clamp(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Reference Bellman update on the model table; returns the expected response.
    task automatic model_update(input int s, input int a, input int ns, input longint r,
                                input int al, input int ga, output sb_item_t it);
        longint qmax;
        longint q;
        longint td;
        longint qn;
        int     best;
        qmax = tbl_m[ns][0];
        for (int i = 1; i < NA; i++) if (tbl_m[ns][i] > qmax) qmax = tbl_m[ns][i];
        best = -1;
        for (int i = 0; i < NA; i++) if (best < 0 && tbl_m[ns][i] == qmax) best = i;
        q  = tbl_m[s][a];
        td = r + floor_div(longint'(ga) * qmax) - q;
        qn = clamp(q + floor_div(longint'(al) * td));
        for (int i = 0; i < NA; i++) it.row[i*DW +: DW] = DW'(tbl_m[ns][i]);
        it.q_new = DW'(qn);
        it.best  = 2'(best);
        it.cyc   = 32'(cyc + 4);
        tbl_m[s][a] = qn;
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++) for (int a = 0; a < NA; a++) tbl_m[s][a] = 0;
    endtask

    // Issue one request on the main DUT; optionally queue the model's expectation.
    task automatic do_update(input int s, input int a, input int ns, input longint r,
                             input int al, input int ga, input bit push);
        sb_item_t it;
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("ready_timeout", in_ready, 1);
            return;
        end
        st = 4'(s); act = 2'(a); nxtst = 4'(ns); rt = DW'(r);
        alpha = CW'(al); gamma = CW'(ga); in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        last_accept = accept_cyc;
        accept_cyc  = cyc;
        st = 4'($urandom); act = 2'($urandom); nxtst = 4'($urandom);
        rt = DW'($urandom); alpha = CW'($urandom); gamma = CW'($urandom);
        if (push) begin
            model_update(s, a, ns, r, al, ga, it);
            sb.push_back(it);
        end
    endtask

    // Wait until every queued response has been seen and the engine is idle.
    task automatic settle();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && in_ready) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL settle_timeout: got queue %0d ready %0b expected empty and ready", sb.size(), in_ready);
    endtask

    // Read every row back through q_row with alpha=0, which leaves the table unchanged.
    task automatic readback_all();
        for (int s = 0; s < NS; s++) begin
            do_update($urandom_range(NS-1), $urandom_range(NA-1), s, 0, 0, $urandom_range(255), 1'b1);
        end
        settle();
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        sb_item_t it;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending update (t=%0t)", $time);
            end else begin
                it = sb.pop_front();
                check("q_new", $signed(q_new), $signed(it.q_new));
                for (int i = 0; i < NA; i++) begin
                    check("q_row_lane", $signed(q_row[i*DW +: DW]), $signed(it.row[i*DW +: DW]));
                end
                check("best_act", best_act, it.best);
                check("done_latency", cyc, it.cyc);
            end
        end
        if (rst_n && err) check("err_main", err, 0);
    end

    initial begin : stimulus
        int n;
        int got;
        longint prev;
        bit prev_back_to_back;

        rst_n = 1'b0; in_valid = 1'b0; clr_req = 1'b0;
        st = '0; nxtst = '0; act = '0; rt = '0; alpha = '0; gamma = '0;
        in_valid12 = 1'b0; clr_req12 = 1'b0;
        st12 = '0; nxtst12 = '0; act12 = '0; rt12 = '0; alpha12 = '0; gamma12 = '0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_clr_busy", clr_busy, 0);
        check("reset_q_row", q_row, 0);
        check("reset_best_act", best_act, 0);
        check("reset_q_new", q_new, 0);

        // First update from an empty table, with the ready-low window measured.
        do_update(3, 1, 5, 256, 128, 192, 1'b1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        check("ready_low_cycles", n, 4);
        settle();
        check("first_q_new", $signed(q_new), 128);
        check("first_q_row", q_row, 0);
        check("first_best", best_act, 0);

        // Chained update: the second request sees the first one's write.
        do_update(5, 2, 0, 100, 128, 64, 1'b1);
        settle();
        check("chain_a_q_new", $signed(q_new), 50);
        do_update(3, 1, 5, 256, 128, 192, 1'b1);
        settle();
        check("chain_b_q_new", $signed(q_new), 210);
        check("chain_b_lane2", $signed(q_row[2*DW +: DW]), 50);
        check("chain_b_best", best_act, 2);

        // Most negative reward, floor shift, tie in a zero row.
        do_update(0, 0, 9, -32768, 255, 0, 1'b1);
        settle();
        check("neg_q_new", $signed(q_new), -32640);
        check("neg_best", best_act, 0);

        // Saturation: self-loop with maximal reward and coefficients.
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            do_update(7, 3, 7, 32767, 255, 255, 1'b1);
            settle();
            check("sat_monotonic", ($signed(q_new) >= prev), 1);
            check("sat_sign", q_new[DW-1], 0);
            prev = $signed(q_new);
        end
        check("sat_final", $signed(q_new), 32767);

        // Randomised updates, mixing back-to-back issue with idle gaps.
        prev_back_to_back = 1'b0;
        for (int i = 0; i < 40; i++) begin
            longint r;
            int gap;
            r = longint'($urandom_range(65535)) - 32768;
            if (i % 8 == 3) r = ($urandom_range(1) != 0) ? 32767 : -32768;
            do_update($urandom_range(NS-1), $urandom_range(NA-1), $urandom_range(NS-1), r,
                      $urandom_range(255), $urandom_range(255), 1'b1);
            if (prev_back_to_back) check("throughput", accept_cyc - last_accept, 5);
            gap = $urandom_range(1);
            prev_back_to_back = (gap == 0);
            if (gap != 0) repeat (7) @(negedge clk);
        end
        settle();

        // Clear wins over a simultaneous request; a repeated clr_req mid-clear is ignored.
        @(negedge clk);
        clr_req = 1'b1; in_valid = 1'b1; st = 4'd2; act = 2'd1; nxtst = 4'd3;
        rt = 16'd1000; alpha = 8'd200; gamma = 8'd10;
        #1;
        check("ready_with_clr", in_ready, 0);
        @(posedge clk);
        #1;
        clr_req = 1'b0; in_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!clr_busy) break;
            n++;
            clr_req = (n == 5);
        end
        clr_req = 1'b0;
        check("clr_busy_cycles", n, 16);
        #1;
        check("ready_after_clr", in_ready, 1);
        model_clear();
        readback_all();

        // Reset during CALC abandons the update and zeroes everything.
        do_update(4, 0, 4, 500, 255, 0, 1'b1);
        settle();
        check("pre_reset_q_new", $signed(q_new), 498);
        do_update(2, 1, 2, 1000, 255, 0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_done", done, 0);
        check("midrst_clr_busy", clr_busy, 0);
        check("midrst_q_row", q_row, 0);
        check("midrst_best", best_act, 0);
        check("midrst_q_new", q_new, 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        readback_all();

        // Out-of-range indices on the 12-state instance.
        @(negedge clk);
        st12 = 4'd13; nxtst12 = 4'd1; act12 = 2'd0; rt12 = 16'd500; alpha12 = 8'd255; gamma12 = 8'd0;
        in_valid12 = 1'b1;
        #1;
        check("r12_ready", in_ready12, 1);
        @(posedge clk);
        #1;
        in_valid12 = 1'b0;
        @(negedge clk);
        check("r12_err_st", err12, 1);
        check("r12_no_done", done12, 0);
        check("r12_ready_after_err", in_ready12, 1);
        @(negedge clk);
        check("r12_err_pulse", err12, 0);
        st12 = 4'd1; nxtst12 = 4'd12; in_valid12 = 1'b1;
        @(posedge clk);
        #1;
        in_valid12 = 1'b0;
        @(negedge clk);
        check("r12_err_nxtst", err12, 1);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done12) n++;
        end
        check("r12_done_count", n, 0);
        st12 = 4'd1; nxtst12 = 4'd1; act12 = 2'd0; rt12 = 16'd40; alpha12 = 8'd128; gamma12 = 8'd0;
        in_valid12 = 1'b1;
        @(posedge clk);
        #1;
        in_valid12 = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            @(negedge clk);
            if (done12) got = 1;
        end
        check("r12_valid_done", got, 1);
        check("r12_valid_q_new", $signed(q_new12), 20);
        check("r12_valid_q_row", q_row12, 0);
        check("r12_valid_err", err12, 0);

        settle();
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/q_learning_accel_param.md
# q_learning_accel_param

Parametrised, handshaked Q-learning update engine. Successor to the fixed 32-bit, 256-state, 4-action accelerator. It holds the Q-table internally and runs one Bellman update per accepted request through a multi-cycle FSM: read, max, compute, write. It returns the next-state Q row and the greedy action to the policy generator, and supports a table-clear command. Alpha and gamma are full fixed-point multipliers, not leading-one shift sums.

## Interface
Parameters:
- DATA_W, 32: signed two's-complement Q value and reward width.
- N_ST, 256: number of states, ≥2. ST_W = clog2(N_ST) is a derived localparam.
- N_ACT, 4: number of actions, ≥2. ACT_W = clog2(N_ACT) is a derived localparam.
- COEF_W, 8: alpha/gamma width, unsigned Q0.COEF_W (value = coef / 2^COEF_W).

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: update request valid.
- in_ready, out, 1: high only in IDLE with no clear pending.
- st, in, ST_W: current state.
- nxtst, in, ST_W: next state.
- act, in, ACT_W: action taken.
- rt, in, DATA_W: signed reward.
- alpha, in, COEF_W: learning rate.
- gamma, in, COEF_W: discount factor.
- clr_req, in, 1: one-cycle request to zero the table.
- clr_busy, out, 1: high during CLEAR.
- done, out, 1: one-cycle pulse when an update commits.
- err, out, 1: one-cycle pulse when a request is dropped for an out-of-range index.
- q_row, out, N_ACT*DATA_W: Q row of nxtst, pre-update; action a occupies bits [a*DATA_W +: DATA_W].
- best_act, out, ACT_W: argmax of q_row.
- q_new, out, DATA_W: value written by the last update.

## Operation
- FSM states: IDLE, READ, MAX, CALC, WRITE, CLEAR.
- IDLE:
  - clr_req → CLEAR. Clear takes priority; a simultaneous in_valid is not accepted.
  - in_valid & in_ready → READ. st, nxtst, act, rt, alpha and gamma are latched.
- Range check at acceptance: if st ≥ N_ST, nxtst ≥ N_ST or act ≥ N_ACT, pulse err next cycle, stay in IDLE, leave the table unchanged.
- READ: register the full nxtst row and Q(st,act). Go to MAX.
- MAX:
  - Signed maximum over the nxtst row → qmax.
  - Ties resolve to the lowest action index → best_act.
  - Go to CALC.
- CALC, all in DATA_W+COEF_W+2 signed internal width:
  - td = rt + ((gamma·qmax) >>> COEF_W) − Q
  - qn = Q + ((alpha·td) >>> COEF_W)
  - Arithmetic shifts floor toward −∞.
  - qn saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Go to WRITE.
- WRITE:
  - Table[st][act] ← qn; q_new ← qn.
  - q_row and best_act are updated to the values registered in READ/MAX.
  - Pulse done. Go to IDLE.
- st == nxtst is legal: q_row shows the pre-update row. The next request sees the written value, since there is no overlap.
- CLEAR: one state index per cycle, 0..N_ST−1, all actions of that index set to 0. clr_busy is high throughout. clr_req during CLEAR is ignored. Return to IDLE after index N_ST−1.
- Table is a flop array.

## Timing
- Reset values: table all 0, FSM IDLE, in_ready 1, done 0, err 0, clr_busy 0, q_row 0, best_act 0, q_new 0.
- Handshake accepted at edge T. done is high in the cycle after edge T+4, and outputs update at T+4. in_ready is low from T+1 through T+4, and high again after T+4.
- Throughput: one update per 5 cycles.
- Clear asserted at edge T: table fully zero and in_ready high after edge T+N_ST.
- An update is only ever visible to a later request, never to one in flight.
- rst_n low at any point, including mid-update or mid-CLEAR: immediately return to reset values. A partial write is not committed, and the table returns to all 0.
- Inputs other than in_valid, clr_req and rst_n are sampled only at acceptance.

## Test plan
All scenarios use DATA_W=16, COEF_W=8, N_ST=16, N_ACT=4.
- Reset: after reset, in_ready=1 and all outputs 0. A request st=3, act=1, nxtst=5, rt=256, alpha=128, gamma=192 → done 5 cycles after acceptance, q_new=128, q_row all 0, best_act=0.
- Chained update: st=5, act=2, nxtst=0, rt=100, alpha=128 → q_new=50. Then repeat the first request → q_row={0,0,50,0}, best_act=2, q_new=210 (td = 256 + 37 − 128 = 165, then 128·165 >>> 8 = 82).
- Negative reward and floor: st=0, act=0, rt=−32768, alpha=255, gamma=0 from a zero table → q_new=−32640. Ties in a zero row → best_act=0.
- Saturation: repeated st=7, act=3, nxtst=7, rt=32767, alpha=255, gamma=255 → Q rises monotonically to 32767 and never wraps negative.
- Clear priority: clr_req and in_valid high in the same cycle → request not accepted, clr_busy high for 16 cycles, all rows read back 0 afterwards.
- Mid-operation reset: assert rst_n low during CALC → that entry stays unchanged (0) and all outputs show reset values.
- Out-of-range indices: these cannot occur at N_ST=16, so re-run with N_ST=12 and drive st=13 → err pulses, no done, table unchanged.
